// File: rtl/bus_arb2_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding, grant
// codes, forced-termination read data and watchdog counter width.
package bus_arb2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [1:0]  GRANT_NONE = 2'b00;
    localparam logic [1:0]  GRANT_M0   = 2'b01;
    localparam logic [1:0]  GRANT_M1   = 2'b10;

    localparam logic [31:0] ERR_DATA   = 32'hFFFF_FFFF;

    localparam int          WDOG_W     = 8;

endpackage

// File: rtl/bus_arb2_wdog.sv
// Grant watchdog: counts granted cycles without an acknowledge, flags the
// cycle in which the transfer must be forced to end, and keeps a sticky flag.
module bus_arb2_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic bus_ack,
    input  logic timeout_clr,
    output logic expire,
    output logic timeout
);
    import bus_arb2_pkg::*;

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [WDOG_W-1:0] count;

    // A real acknowledge in the limit cycle takes priority over the forced end.
    assign expire = active & ~bus_ack & (count == LIMIT);

    // Every grant is preceded by an IDLE cycle, which is where the count restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            timeout <= 1'b0;
        end else begin
            if (!active) begin
                count <= '0;
            end else if (!bus_ack) begin
                count <= count + 1'b1;
            end

            if (expire) begin
                timeout <= 1'b1;
            end else if (timeout_clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_arb2.sv
// Round-robin arbiter sharing one strobe/acknowledge slave bus between two
// masters. Define BUS_ARB2_TIMEOUT_EN to build the grant watchdog.
module bus_arb2 #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [21:0] m0_addr,
    input  logic [31:0] m0_dout,
    output logic [31:0] m0_din,
    output logic        m0_ack,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [21:0] m1_addr,
    input  logic [31:0] m1_dout,
    output logic [31:0] m1_din,
    output logic        m1_ack,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [21:0] bus_addr,
    output logic [31:0] bus_dout,
    input  logic [31:0] bus_din,
    input  logic        bus_ack,
    output logic [1:0]  grant,
    output logic        timeout,
    input  logic        timeout_clr
);
    import bus_arb2_pkg::*;

    state_t state, state_next;
    logic   last, last_next;
    logic   sel0, sel1;
    logic   expire;

    assign sel0 = (state == GNT0);
    assign sel1 = (state == GNT1);

`ifdef BUS_ARB2_TIMEOUT_EN
    bus_arb2_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk         (clk),
        .rst         (rst),
        .active      (sel0 | sel1),
        .bus_ack     (bus_ack),
        .timeout_clr (timeout_clr),
        .expire      (expire),
        .timeout     (timeout)
    );
`else
    logic unused_cfg;
    assign expire     = 1'b0;
    assign timeout    = 1'b0;
    assign unused_cfg = ^{timeout_clr, 8'(TIMEOUT_CYCLES)};
`endif

    // Read data goes to both masters; only the acknowledged one consumes it.
    assign m0_din = (sel0 & expire) ? ERR_DATA : bus_din;
    assign m1_din = (sel1 & expire) ? ERR_DATA : bus_din;

    // last resets to 1 so that m0 wins the first simultaneous request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_next;
            last  <= last_next;
        end
    end

    always_comb begin
        state_next = state;
        last_next  = last;
        bus_stb    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_dout   = '0;
        grant      = GRANT_NONE;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (m0_stb && (!m1_stb || last)) begin
                    state_next = GNT0;
                end else if (m1_stb) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                bus_stb  = m0_stb & ~expire;
                bus_we   = m0_we;
                bus_addr = m0_addr;
                bus_dout = m0_dout;
                grant    = GRANT_M0;
                m0_ack   = bus_ack | expire;
                if (bus_ack || expire) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
            end
            GNT1: begin
                bus_stb  = m1_stb & ~expire;
                bus_we   = m1_we;
                bus_addr = m1_addr;
                bus_dout = m1_dout;
                grant    = GRANT_M1;
                m1_ack   = bus_ack | expire;
                if (bus_ack || expire) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arb2.sv
// Scoreboard bench for bus_arb2: masters push expected responses, a monitor
// pops them on each acknowledge and checks grant order against the fairness rules.
module tb_bus_arb2;

    localparam int TO_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_stb = 1'b0, m0_we = 1'b0;
    logic [21:0] m0_addr = '0;
    logic [31:0] m0_dout = '0;
    logic [31:0] m0_din;
    logic        m0_ack;
    logic        m1_stb = 1'b0, m1_we = 1'b0;
    logic [21:0] m1_addr = '0;
    logic [31:0] m1_dout = '0;
    logic [31:0] m1_din;
    logic        m1_ack;
    logic        bus_stb, bus_we;
    logic [21:0] bus_addr;
    logic [31:0] bus_dout;
    logic [31:0] bus_din = '0;
    logic        bus_ack = 1'b0;
    logic [1:0]  grant;
    logic        timeout;
    logic        timeout_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] dout;
        logic [31:0] din;
    } txn_t;

    txn_t q0[$];
    txn_t q1[$];

    logic        slave_en   = 1'b1;
    logic        slave_rand = 1'b0;
    logic        use_fixed  = 1'b0;
    logic        force_ack  = 1'b0;
    int          slave_lat  = 0;
    logic [31:0] fixed_din  = '0;

    bus_arb2 #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
        .m0_din(m0_din), .m0_ack(m0_ack),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
        .m1_din(m1_din), .m1_ack(m1_ack),
        .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_din(bus_din), .bus_ack(bus_ack),
        .grant(grant), .timeout(timeout), .timeout_clr(timeout_clr)
    );

    always #5 clk = ~clk;

    // Slave memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] rom(input logic [21:0] a);
        return {a[9:0], a} ^ 32'hA5C3_1E77;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic startTxn(input int m, input logic we, input logic [21:0] a,
                            input logic [31:0] d, input logic [31:0] din_exp, input bit push);
        txn_t t;
        t.we = we; t.addr = a; t.dout = d; t.din = din_exp;
        if (m == 0) begin
            m0_we = we; m0_addr = a; m0_dout = d; m0_stb = 1'b1;
            if (push) q0.push_back(t);
        end else begin
            m1_we = we; m1_addr = a; m1_dout = d; m1_stb = 1'b1;
            if (push) q1.push_back(t);
        end
    endtask

    task automatic dropTxn(input int m);
        if (m == 0) m0_stb = 1'b0;
        else        m1_stb = 1'b0;
    endtask

    task automatic waitAck(input int m);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((m == 0) ? m0_ack : m1_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput((m == 0) ? "ack_wait_m0" : "ack_wait_m1", 64'(ok), 64'd1);
    endtask

    // Issues n random transfers on master m, called at negedge+1.
    task automatic applyStimulus(input int m, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int          gap;
            logic        we;
            logic [21:0] a;
            logic [31:0] d;
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                #1;
            end
            we = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 22'h3FFFFF : 22'($urandom);
            d  = $urandom;
            startTxn(m, we, a, d, we ? 32'h0 : rom(a), 1'b1);
            waitAck(m);
            #1 dropTxn(m);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #1 rst = 1'b0;
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Slave: once it sees a strobe it acknowledges slave_lat cycles later.
    initial begin : slave
        int   scnt;
        logic busy;
        scnt = 0;
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (force_ack) begin
                bus_ack = 1'b1;
                bus_din = 32'h0BAD_0BAD;
            end else if (!rst || !slave_en) begin
                busy    = 1'b0;
                bus_ack = 1'b0;
            end else begin
                if (!busy && bus_stb) begin
                    busy = 1'b1;
                    scnt = 0;
                end
                if (busy && scnt == slave_lat) begin
                    bus_ack = 1'b1;
                    bus_din = use_fixed ? fixed_din : rom(bus_addr);
                    busy    = 1'b0;
                    if (slave_rand) slave_lat = $urandom_range(0, 3);
                end else begin
                    bus_ack = 1'b0;
                    if (busy) scnt++;
                end
            end
        end
    end

    // Monitor: predicts grant from the previous cycle's requests and pops the scoreboard on acks.
    initial begin : monitor
        logic [1:0] prev_req, prev_gnt, exp_gnt;
        logic       prev_ack, last_m;
        txn_t       t;
        prev_req = '0; prev_gnt = '0; prev_ack = 1'b0; last_m = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_m   = 1'b1;
                prev_gnt = '0;
                prev_ack = 1'b0;
            end else begin
                if (prev_gnt == 2'b00) begin
                    case (prev_req)
                        2'b01:   exp_gnt = 2'b01;
                        2'b10:   exp_gnt = 2'b10;
                        2'b11:   exp_gnt = last_m ? 2'b01 : 2'b10;
                        default: exp_gnt = 2'b00;
                    endcase
                end else if (prev_ack) begin
                    exp_gnt = 2'b00;
                end else begin
                    exp_gnt = prev_gnt;
                end
                checkOutput("grant_seq", 64'(grant), 64'(exp_gnt));
                if (grant == 2'b00)
                    checkOutput("idle_bus", 64'({bus_stb, bus_we, bus_addr, bus_dout}), 64'd0);
                if (bus_ack)
                    checkOutput("ack_route", 64'({m1_ack, m0_ack}), 64'(grant));
                if (m0_ack) begin
                    if (q0.size() == 0) checkOutput("m0_unexpected_ack", 64'd1, 64'd0);
                    else begin
                        t = q0.pop_front();
                        checkOutput("m0_slave_side", 64'({bus_we, bus_addr, bus_dout}), 64'({t.we, t.addr, t.dout}));
                        if (!t.we) checkOutput("m0_rdata", 64'(m0_din), 64'(t.din));
                    end
                    last_m = 1'b0;
                end
                if (m1_ack) begin
                    if (q1.size() == 0) checkOutput("m1_unexpected_ack", 64'd1, 64'd0);
                    else begin
                        t = q1.pop_front();
                        checkOutput("m1_slave_side", 64'({bus_we, bus_addr, bus_dout}), 64'({t.we, t.addr, t.dout}));
                        if (!t.we) checkOutput("m1_rdata", 64'(m1_din), 64'(t.din));
                    end
                    last_m = 1'b1;
                end
                prev_gnt = grant;
                prev_ack = m0_ack | m1_ack;
            end
            #2 prev_req = {m1_stb, m0_stb};
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL global_timeout: bench did not finish within 100000 time units");
        $fatal(1, "[TB] stopped by global timeout");
    end

    initial begin : main
        logic [1:0] alt_seq [8];
        logic [1:0] alt_exp [8];
        txn_t       t;
        alt_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

        // Reset state
        @(negedge clk);
        checkOutput("reset_outputs", 64'({bus_stb, grant, m0_ack, m1_ack, timeout}), 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        #1;

        // m0 read, slave acks in the third granted cycle
        slave_lat = 2; use_fixed = 1'b1; fixed_din = 32'h1234_5678;
        startTxn(0, 1'b0, 22'h000100, 32'h0, 32'h1234_5678, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("t1_grant", 64'(grant), 64'(2'b01));
            checkOutput("t1_acks", 64'({m1_ack, m0_ack}), (k == 3) ? 64'd1 : 64'd0);
            if (k == 3) checkOutput("t1_rdata", 64'(m0_din), 64'h1234_5678);
        end
        #1 dropTxn(0);

        // Both masters request together after reset and keep requesting
        doReset();
        slave_lat = 0; use_fixed = 1'b0;
        fork
            applyStimulus(0, 3, 0);
            applyStimulus(1, 3, 0);
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge clk);
                    alt_seq[k] = grant;
                end
            end
        join
        for (int k = 0; k < 8; k++) checkOutput("alt_grant", 64'(alt_seq[k]), 64'(alt_exp[k]));

        // m1 write at the top of the address space
        settle();
        slave_lat = 1;
        startTxn(1, 1'b1, 22'h3FFFFF, 32'hDEAD_BEEF, 32'h0, 1'b1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            checkOutput("t3_bus", 64'({grant, bus_we, bus_addr, bus_dout}),
                        64'({2'b10, 1'b1, 22'h3FFFFF, 32'hDEAD_BEEF}));
        end
        #1 dropTxn(1);
        @(negedge clk);
        checkOutput("t3_idle_dout", 64'({grant, bus_dout}), 64'd0);

        // Acknowledge while idle is ignored
        #1 force_ack = 1'b1;
        @(negedge clk);
        checkOutput("idle_ack_ignored", 64'({grant, m1_ack, m0_ack}), 64'd0);
        #1 force_ack = 1'b0;
        @(negedge clk);
        checkOutput("idle_ack_no_grant", 64'(grant), 64'd0);

        // Reset asserted in the middle of an m1 transfer
        #1 slave_en = 1'b0;
        startTxn(1, 1'b0, 22'h000200, 32'h0, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (grant == 2'b10) break;
        end
        checkOutput("t4_granted_m1", 64'({grant, bus_stb}), 64'({2'b10, 1'b1}));
        #2 rst = 1'b0;
        #1 checkOutput("t4_async_reset", 64'({bus_stb, grant, m0_ack, m1_ack}), 64'd0);
        t.we = 1'b0; t.addr = 22'h000200; t.dout = 32'h0; t.din = rom(22'h000200);
        q1.push_back(t);
        startTxn(0, 1'b1, 22'h000010, 32'h0F0F_0F0F, 32'h0, 1'b1);
        slave_en = 1'b1; slave_lat = 0;
        @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        checkOutput("t4_m0_wins", 64'({grant, m0_ack}), 64'({2'b01, 1'b1}));
        #1 dropTxn(0);
        waitAck(1);
        #1 dropTxn(1);

        // Randomized traffic on both masters
        settle();
        slave_rand = 1'b1;
        fork
            applyStimulus(0, 40, 3);
            applyStimulus(1, 40, 3);
        join
        slave_rand = 1'b0;
        settle();

`ifdef BUS_ARB2_TIMEOUT_EN
        // Slave never answers: forced termination in the last allowed cycle
        slave_en = 1'b0;
        startTxn(0, 1'b0, 22'h000055, 32'h0, 32'hFFFF_FFFF, 1'b1);
        for (int k = 1; k <= TO_CYCLES; k++) begin
            @(negedge clk);
            if (k < TO_CYCLES) checkOutput("to_wait", 64'({grant, m0_ack}), 64'({2'b01, 1'b0}));
            else begin
                checkOutput("to_force", 64'({m0_ack, bus_stb}), 64'({1'b1, 1'b0}));
                checkOutput("to_errdata", 64'(m0_din), 64'hFFFF_FFFF);
            end
        end
        #1 dropTxn(0);
        @(negedge clk);
        checkOutput("to_flag_set", 64'(timeout), 64'd1);
        repeat (2) @(negedge clk);
        checkOutput("to_flag_sticky", 64'(timeout), 64'd1);
        #1 timeout_clr = 1'b1;
        @(negedge clk);
        checkOutput("to_flag_clear", 64'(timeout), 64'd0);
        #1 timeout_clr = 1'b0;

        // Real acknowledge coinciding with the limit wins
        slave_en = 1'b1; slave_lat = TO_CYCLES - 1; use_fixed = 1'b1; fixed_din = 32'h0000_00AA;
        startTxn(0, 1'b0, 22'h000056, 32'h0, 32'h0000_00AA, 1'b1);
        for (int k = 1; k <= TO_CYCLES; k++) begin
            @(negedge clk);
            if (k == TO_CYCLES) begin
                checkOutput("to_tie_ack", 64'(m0_ack), 64'd1);
                checkOutput("to_tie_data", 64'(m0_din), 64'h0000_00AA);
            end
        end
        #1 dropTxn(0);
        @(negedge clk);
        checkOutput("to_tie_flag", 64'(timeout), 64'd0);
`endif

        @(negedge clk);
        checkOutput("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
